// File: rtl/moore_t_counter.sv
// Moore-style bank of WIDTH T flip-flops: independent toggle, chained up/down
// count, hold, parallel load, optional saturation and a registered wrap flag.
module moore_t_counter #(
    parameter int              WIDTH     = 4,
    parameter int              SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] z,
    output logic             tc_max,
    output logic             tc_min,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_INDEP = 2'b00,
        MODE_UP    = 2'b01,
        MODE_DOWN  = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t;
    logic             wrap_reg;
    logic             wrap_next;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the reset is synchronous, so it lives inside the edge block.
    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= RESET_VAL;
            wrap_reg <= 1'b0;
        end else begin
            q        <= q_next;
            wrap_reg <= wrap_next;
        end
    end

    // Toggle vector for each mode; a chain that runs through every bit means
    // the counter is sitting at its terminal value.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        logic chain;
        t         = '0;
        wrap_next = 1'b0;
        chain     = 1'b1;
        if (en) begin
            case (mode_e'(mode))
                MODE_INDEP: t = t_in;
                MODE_UP: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        t[i]  = chain;
                        chain = chain & q[i];
                    end
                end
                MODE_DOWN: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        t[i]  = chain;
                        chain = chain & ~q[i];
                    end
                end
                default: t = '0;
            endcase
            if ((mode_e'(mode) == MODE_UP || mode_e'(mode) == MODE_DOWN) && chain) begin
                if (SATURATE != 0) begin
                    t = '0;
                end else begin
                    wrap_next = 1'b1;
                end
            end
        end
        q_next = q ^ t;
        if (load) begin
            q_next    = load_val;
            wrap_next = 1'b0;
        end
    end

    assign z      = q;
    assign tc_max = &q;
    assign tc_min = ~|q;
    assign wrap   = wrap_reg;

endmodule
